// File: rtl/ifetch_ctrl_pkg.sv
// ifetch_ctrl_pkg: shared constants and fetch-packet layout for the fetch sequencer
package ifetch_ctrl_pkg;
    localparam int DEF_ADDR = 32;
    localparam int DEF_WORD = 32;
    localparam logic [DEF_ADDR-1:0] DEF_RESET_PC = '0;
    localparam int INSN_ALIGN = 4;

    typedef struct packed {
        logic [DEF_ADDR-1:0] pc;
        logic [DEF_WORD-1:0] insn;
    } fetch_pkt_t;

    localparam int PKT_W = $bits(fetch_pkt_t);
endpackage

// File: rtl/ifetch_ctrl_if.sv
// ifetch_ctrl_if: control, ROM and decode-side signals of the fetch sequencer
interface ifetch_ctrl_if import ifetch_ctrl_pkg::*; #(
    parameter int ADDR = DEF_ADDR,
    parameter int WORD = DEF_WORD
);
    logic            fetch_en;
    logic            redirect_valid;
    logic [ADDR-1:0] redirect_pc;
    logic [ADDR-1:0] rom_addr;
    logic [WORD-1:0] rom_dout;
    logic            out_valid;
    logic            out_ready;
    logic [ADDR-1:0] out_pc;
    logic [WORD-1:0] out_insn;

    modport master (
        input  fetch_en, redirect_valid, redirect_pc, rom_dout, out_ready,
        output rom_addr, out_valid, out_pc, out_insn
    );

    modport slave (
        output fetch_en, redirect_valid, redirect_pc, rom_dout, out_ready,
        input  rom_addr, out_valid, out_pc, out_insn
    );
endinterface

// File: rtl/ifetch_ctrl_fetch_fifo.sv
// fetch_fifo: shift-register FIFO with flush whose head entry is always slot 0 (registered output)
module fetch_fifo import ifetch_ctrl_pkg::*; #(
    parameter int W     = PKT_W,
    parameter int DEPTH = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       flush,
    input  logic                       push,
    input  logic                       pop,
    input  logic [W-1:0]               din,
    output logic [W-1:0]               head,
    output logic [$clog2(DEPTH+1)-1:0] count
);
    localparam int CW = $clog2(DEPTH+1);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_idx;

    assign wr_idx = AW'(count - CW'(pop));
    assign head   = mem[0];

    // Shift toward slot 0 on pop, write behind the surviving entries on push; flush/reset empty and zero it
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            count <= '0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else begin
            if (pop) begin
                for (int i = 0; i < DEPTH - 1; i++) mem[i] <= mem[i+1];
                mem[DEPTH-1] <= '0;
            end
            if (push) mem[wr_idx] <= din;
            count <= count + CW'(push) - CW'(pop);
        end
    end

    a_no_overflow: assert property (@(posedge clk) disable iff (rst)
        !(push && !pop && !flush && count == CW'(DEPTH)));
endmodule

// File: rtl/ifetch_ctrl.sv
// ifetch_ctrl: PC sequencer issuing ROM reads and absorbing the one-cycle ROM latency in a FIFO
module ifetch_ctrl import ifetch_ctrl_pkg::*; #(
    parameter int              ADDR     = DEF_ADDR,
    parameter int              WORD     = DEF_WORD,
    parameter logic [ADDR-1:0] RESET_PC = ADDR'(DEF_RESET_PC),
    parameter int              DEPTH    = 2
) (
    input logic          clk,
    input logic          rst,
    ifetch_ctrl_if.master bus
);
    localparam int CW = $clog2(DEPTH+1);

    logic [ADDR-1:0]      pc_q;
    logic [ADDR-1:0]      inflight_pc_q;
    logic                 inflight_q;
    logic [ADDR-1:0]      tgt;
    logic                 pop;
    logic                 push;
    logic                 issue;
    logic [CW-1:0]        count;
    logic [CW:0]          occ;
    logic [ADDR+WORD-1:0] head;

    assign tgt           = {bus.redirect_pc[ADDR-1:2], 2'b00};
    assign bus.rom_addr  = rst ? RESET_PC : bus.redirect_valid ? tgt : pc_q;
    assign bus.out_valid = count != '0;
    assign pop           = bus.out_valid & bus.out_ready;
    assign occ           = {1'b0, count} + (CW+1)'(inflight_q) - (CW+1)'(pop);
    assign issue         = bus.fetch_en & ~rst & (bus.redirect_valid | (occ < (CW+1)'(DEPTH)));
    assign push          = inflight_q & ~bus.redirect_valid;
    assign {bus.out_pc, bus.out_insn} = head;

    // PC advance, redirect load and in-flight read tracking
    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q          <= RESET_PC;
            inflight_q    <= 1'b0;
            inflight_pc_q <= '0;
        end else begin
            inflight_q <= issue;
            if (issue) begin
                inflight_pc_q <= bus.rom_addr;
                pc_q          <= bus.rom_addr + ADDR'(INSN_ALIGN);
            end else if (bus.redirect_valid) begin
                pc_q <= tgt;
            end
        end
    end

    fetch_fifo #(.W(ADDR+WORD), .DEPTH(DEPTH)) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .flush (bus.redirect_valid),
        .push  (push),
        .pop   (pop),
        .din   ({inflight_pc_q, bus.rom_dout}),
        .head  (head),
        .count (count)
    );
endmodule
